// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter: FSM state encoding and default constants.
package freq_meter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        GATE = 1'b1
    } state_e;

    localparam int CLK_HZ_DEFAULT = 100_000_000;
    localparam int GATE_500MS     = 50_000_000;
    localparam int CNT_W_DEFAULT  = 26;

endpackage

// File: rtl/freq_meter_if.sv
// Control, measured signal and result bundle of the frequency meter.
interface freq_meter_if #(
    parameter int CNT_W = 26
);
    logic             en;
    logic             sig_in;
    logic [CNT_W-1:0] freq_cnt;
    logic             cnt_valid;
    logic             ovf;

    modport master (
        output en,
        output sig_in,
        input  freq_cnt,
        input  cnt_valid,
        input  ovf
    );

    modport slave (
        input  en,
        input  sig_in,
        output freq_cnt,
        output cnt_valid,
        output ovf
    );
endinterface

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input followed by a one-cycle rising-edge pulse.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o
);
    logic meta_q;
    logic sync_q;
    logic syncDly_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q    <= 1'b0;
            sync_q    <= 1'b0;
            syncDly_q <= 1'b0;
        end else begin
            meta_q    <= async_i;
            sync_q    <= meta_q;
            syncDly_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~syncDly_q;
endmodule

// File: rtl/freq_meter.sv
// Gated frequency meter: counts synchronized sig_in rising edges over back-to-back
// windows of GATE_CYCLES clocks and publishes each count with a one-cycle strobe.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int CLK_HZ      = CLK_HZ_DEFAULT,
    parameter int GATE_CYCLES = GATE_500MS,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    freq_meter_if.slave  bus
);
    localparam int            GW        = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

    generate
        if (CLK_HZ <= 0 || GATE_CYCLES < 4) begin : gBadCfg
            $error("freq_meter: CLK_HZ must be positive and GATE_CYCLES at least 4");
        end
    endgenerate

    state_e           state_q, state_d;
    logic [GW-1:0]    gateCnt_q, gateCnt_d;
    logic [CNT_W-1:0] edgeCnt_q, edgeCnt_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] freqCnt_q, freqCnt_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;

    logic             sigRise;
    logic [CNT_W:0]   edgeSum;
    logic [CNT_W-1:0] cntInc;
    logic             satInc;

    sync_edge_det uSync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (bus.sig_in),
        .rise_o  (sigRise)
    );

    // Edge counter sticks at all-ones; the sticky flag records that an edge was lost.
    assign edgeSum = {1'b0, edgeCnt_q} + {{CNT_W{1'b0}}, sigRise};
    assign cntInc  = edgeSum[CNT_W] ? {CNT_W{1'b1}} : edgeSum[CNT_W-1:0];
    assign satInc  = sat_q | edgeSum[CNT_W];

    always_comb begin
        state_d   = state_q;
        gateCnt_d = gateCnt_q;
        edgeCnt_d = edgeCnt_q;
        sat_d     = sat_q;
        freqCnt_d = freqCnt_q;
        ovf_d     = ovf_q;
        valid_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    state_d   = GATE;
                    gateCnt_d = '0;
                    edgeCnt_d = '0;
                    sat_d     = 1'b0;
                end
            end
            GATE: begin
                // The final window cycle publishes even if en drops on it.
                if (gateCnt_q == GATE_LAST) begin
                    freqCnt_d = cntInc;
                    ovf_d     = satInc;
                    valid_d   = 1'b1;
                    gateCnt_d = '0;
                    edgeCnt_d = '0;
                    sat_d     = 1'b0;
                    state_d   = bus.en ? GATE : IDLE;
                end else if (!bus.en) begin
                    state_d = IDLE;
                end else begin
                    gateCnt_d = gateCnt_q + GW'(1);
                    edgeCnt_d = cntInc;
                    sat_d     = satInc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gateCnt_q <= '0;
            edgeCnt_q <= '0;
            sat_q     <= 1'b0;
            freqCnt_q <= '0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            gateCnt_q <= gateCnt_d;
            edgeCnt_q <= edgeCnt_d;
            sat_q     <= sat_d;
            freqCnt_q <= freqCnt_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.freq_cnt  = freqCnt_q;
    assign bus.cnt_valid = valid_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: two instances (6-bit and 5-bit results) share one
// stimulus; a window/edge-timestamp model predicts every strobe, count and overflow flag.
module tb_freq_meter;
    localparam int N = 100;

    typedef enum {SIG_MANUAL, SIG_PERIODIC, SIG_RANDOM} sigMode_e;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    freq_meter_if #(.CNT_W(6)) bus6 ();
    freq_meter_if #(.CNT_W(5)) bus5 ();

    freq_meter #(.CLK_HZ(100_000_000), .GATE_CYCLES(N), .CNT_W(6)) dut6 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus6)
    );

    freq_meter #(.CLK_HZ(100_000_000), .GATE_CYCLES(N), .CNT_W(5)) dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus5)
    );

    int       cyc = 0;
    int       totalChecks = 0;
    int       badChecks = 0;
    int       riseQ[$];
    sigMode_e sigMode = SIG_MANUAL;
    int       sigHalf = 0;
    int       phaseCnt = 0;
    int       phaseLen = 1;
    logic     sigLvl = 1'b0;

    bit runOn = 1'b0;
    int firstStrobe = 0;
    int offAt = -1;
    int expFreq6 = 0, expOvf6 = 0, expFreq5 = 0, expOvf5 = 0;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic driveSig(input logic v);
        if (v && !sigLvl) riseQ.push_back(cyc);
        sigLvl      = v;
        bus6.sig_in = v;
        bus5.sig_in = v;
    endtask

    // Changes en at a falling edge and records when the model expects windows to close.
    task automatic applyStimulus(input logic enVal);
        bus6.en = enVal;
        bus5.en = enVal;
        if (enVal) begin
            runOn       = 1'b1;
            firstStrobe = cyc + 1 + N;
            offAt       = -1;
        end else begin
            offAt = cyc;
        end
    endtask

    task automatic setSigMode(input sigMode_e mode, input int half);
        sigMode  = mode;
        sigHalf  = half;
        phaseCnt = 0;
        phaseLen = (mode == SIG_RANDOM) ? int'($urandom_range(1, 6)) : half;
        if (mode == SIG_MANUAL) driveSig(1'b0);
    endtask

    task automatic switchSig(input sigMode_e mode, input int half);
        #2 setSigMode(mode, half);
        @(negedge clk);
    endtask

    task automatic waitUntil(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic waitStrobe(input int maxCycles, output int at);
        at = -1;
        for (int i = 0; i < maxCycles; i++) begin
            @(negedge clk);
            if (bus6.cnt_valid === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic pulseSig();
        driveSig(1'b1);
        @(negedge clk);
        driveSig(1'b0);
    endtask

    // A rise driven after posedge P is counted by the edge sampled at posedge P+3.
    function automatic int windowCount(input int hi);
        int n = 0;
        foreach (riseQ[i])
            if (riseQ[i] + 3 > hi - N && riseQ[i] + 3 <= hi) n++;
        return n;
    endfunction

    always @(negedge clk) begin
        if (sigMode != SIG_MANUAL) begin
            phaseCnt++;
            if (phaseCnt >= phaseLen) begin
                phaseCnt = 0;
                driveSig(!sigLvl);
                phaseLen = (sigMode == SIG_RANDOM) ? int'($urandom_range(1, 6)) : sigHalf;
            end
        end
    end

    always @(negedge clk) begin : monitor
        bit strobeExp;
        int n;
        if (rst_n === 1'b0) begin
            checkOutput("rstValid6", bus6.cnt_valid, 0);
            checkOutput("rstFreq6", bus6.freq_cnt, 0);
            checkOutput("rstOvf6", bus6.ovf, 0);
            checkOutput("rstValid5", bus5.cnt_valid, 0);
            checkOutput("rstFreq5", bus5.freq_cnt, 0);
            checkOutput("rstOvf5", bus5.ovf, 0);
        end else begin
            strobeExp = runOn && cyc >= firstStrobe && ((cyc - firstStrobe) % N == 0)
                        && (offAt < 0 || cyc <= offAt + 1);
            if (strobeExp) begin
                n        = windowCount(cyc);
                expFreq6 = (n > 63) ? 63 : n;
                expOvf6  = (n > 63) ? 1 : 0;
                expFreq5 = (n > 31) ? 31 : n;
                expOvf5  = (n > 31) ? 1 : 0;
            end
            checkOutput("valid6", bus6.cnt_valid, strobeExp);
            checkOutput("freq6", bus6.freq_cnt, expFreq6);
            checkOutput("ovf6", bus6.ovf, expOvf6);
            checkOutput("valid5", bus5.cnt_valid, strobeExp);
            checkOutput("freq5", bus5.freq_cnt, expFreq5);
            checkOutput("ovf5", bus5.ovf, expOvf5);
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        int e, at, s, s1, s2, s3, s4, r;
        rst_n   = 1'b0;
        bus6.en = 1'b0;
        bus5.en = 1'b0;
        driveSig(1'b0);

        // Reset with sig_in toggling, then a quiet release.
        setSigMode(SIG_PERIODIC, 1);
        repeat (4) @(negedge clk);
        switchSig(SIG_MANUAL, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // Period-10 input: first strobe latency and steady count of 10.
        switchSig(SIG_PERIODIC, 5);
        applyStimulus(1'b1);
        e = cyc;
        waitStrobe(N + 10, at);
        checkOutput("firstLatency", at - e, N + 1);
        repeat (3 * N) @(negedge clk);
        checkOutput("period10", bus6.freq_cnt, 10);

        // Toggle every cycle: 50 edges saturate the 5-bit meter, then a slow input clears ovf.
        switchSig(SIG_PERIODIC, 1);
        waitStrobe(N + 5, at);
        waitStrobe(N + 5, at);
        checkOutput("fastFreq5", bus5.freq_cnt, 31);
        checkOutput("fastOvf5", bus5.ovf, 1);
        checkOutput("fastFreq6", bus6.freq_cnt, 50);
        checkOutput("fastOvf6", bus6.ovf, 0);
        switchSig(SIG_PERIODIC, 7);
        waitStrobe(N + 5, at);
        waitStrobe(N + 5, at);
        checkOutput("slowOvf5", bus5.ovf, 0);

        // Abort at gate count 50, re-enable, then drop en on a final window cycle.
        waitStrobe(N + 5, s);
        waitUntil(s + 50);
        applyStimulus(1'b0);
        repeat (30) @(negedge clk);
        checkOutput("abortHold6", bus6.freq_cnt, expFreq6);
        applyStimulus(1'b1);
        e = cyc;
        waitStrobe(N + 10, at);
        checkOutput("restartLatency", at - e, N + 1);
        waitUntil(at + N - 1);
        applyStimulus(1'b0);
        waitStrobe(5, s);
        checkOutput("finalCycleEnDrop", s, at + N);
        repeat (5) @(negedge clk);

        // Single edges placed on the final gate cycle and on the restart cycle.
        switchSig(SIG_MANUAL, 0);
        repeat (2) @(negedge clk);
        applyStimulus(1'b1);
        s1 = cyc + 1 + N;
        s2 = s1 + N;
        s3 = s2 + N;
        s4 = s3 + N;
        waitUntil(s1);
        checkOutput("quietWindow", bus6.freq_cnt, 0);
        waitUntil(s2 - 3);
        pulseSig();
        waitUntil(s2);
        checkOutput("finalEdgeValid", bus6.cnt_valid, 1);
        checkOutput("finalEdgeCount", bus6.freq_cnt, 1);
        waitUntil(s3 - 4);
        pulseSig();
        waitUntil(s3 - 2);
        pulseSig();
        waitUntil(s3);
        checkOutput("preRestartCount", bus6.freq_cnt, 1);
        waitUntil(s4);
        checkOutput("restartEdgeCount", bus6.freq_cnt, 1);

        // Random input, asynchronous reset mid-window, restart with en still high.
        switchSig(SIG_RANDOM, 0);
        waitStrobe(N + 5, s);
        waitUntil(s + 40);
        #2;
        rst_n    = 1'b0;
        runOn    = 1'b0;
        expFreq6 = 0;
        expOvf6  = 0;
        expFreq5 = 0;
        expOvf5  = 0;
        setSigMode(SIG_MANUAL, 0);
        #1;
        checkOutput("asyncRstFreq", bus6.freq_cnt, 0);
        checkOutput("asyncRstValid", bus6.cnt_valid, 0);
        checkOutput("asyncRstOvf", bus5.ovf, 0);
        repeat (4) @(negedge clk);
        #2;
        rst_n       = 1'b1;
        r           = cyc;
        runOn       = 1'b1;
        firstStrobe = r + 1 + N;
        offAt       = -1;
        @(negedge clk);
        switchSig(SIG_RANDOM, 0);
        waitStrobe(N + 10, at);
        checkOutput("postResetLatency", at - r, N + 1);
        repeat (N + 5) @(negedge clk);

        applyStimulus(1'b0);
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end
endmodule
